div_unit: RTL and testbench

Iterative 32-bit integer divider for the execute stage, handling the DIV/MOD/DIVU/MODU operations.
- Fed from the same operand/opcode path as the arithmetic-logic unit.
- Its result merges into the execute-stage result mux when the opcode is a divide class.
- Replaces the single-cycle combinational divide with a radix-2 restoring divider, taking 32 iteration cycles, behind a valid/ready handshake, so the stage can stall on it.

---
 rtl/div_unit.sv | 114 +++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring 32-bit divider (DIV/MOD/DIVU/MODU), optional DIV_ZERO_FAST_EN
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [1:0]  op_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic        sx;
  logic        sy;
  logic        y_zero;
  logic [31:0] x_q;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  cnt;

  logic        accept;
  logic        is_signed;
  logic [31:0] abs_x;
  logic [31:0] abs_y;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        no_borrow;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] res;

  assign ready_o   = (state == IDLE);
  assign valid_o   = (state == DONE);
  assign accept    = valid_i & ready_o & ~flush_i;
  assign is_signed = ~op_i[1];
  assign abs_x     = (x_i[31] & is_signed) ? -x_i : x_i;
  assign abs_y     = (y_i[31] & is_signed) ? -y_i : y_i;

  // one restoring step: shift in dividend msb, trial subtract on a 33-bit path
  assign rem_shift = {rem, dvd[31]};
  assign diff      = rem_shift - {1'b0, dvs};
  assign no_borrow = ~diff[32];

  // sign fixup and divide-by-zero override from latched state
  assign q_fix    = (sx ^ sy) ? -dvd : dvd;
  assign r_fix    = sx ? -rem : rem;
  assign res      = y_zero ? (op_q[0] ? x_q : 32'hFFFF_FFFF) : (op_q[0] ? r_fix : q_fix);
  assign result_o = valid_o ? res : 32'd0;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; flush overrides acceptance and consumption
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (y_i == 32'd0) ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // operand latch on accept, iteration datapath while calculating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'd0;
      sx     <= 1'b0;
      sy     <= 1'b0;
      y_zero <= 1'b0;
      x_q    <= 32'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      rem    <= 32'd0;
      cnt    <= 5'd0;
    end else if (accept) begin
      op_q   <= op_i;
      sx     <= x_i[31] & is_signed;
      sy     <= y_i[31] & is_signed;
      y_zero <= (y_i == 32'd0);
      x_q    <= x_i;
      dvd    <= abs_x;
      dvs    <= abs_y;
      rem    <= 32'd0;
      cnt    <= 5'd0;
    end else if (state == CALC) begin
      rem <= no_borrow ? diff[31:0] : rem_shift[31:0];
      dvd <= {dvd[30:0], no_borrow};
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic [1:0]  op_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb_q[$];

  div_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .y_i(y_i), .op_i(op_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference behaviour of the four divide ops
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (op[1]) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return op[0] ? r : q;
  endfunction

  function automatic int lat_exp(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    return (y == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // issue one op, measure latency, optionally backpressure, then consume and score
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                        input logic [31:0] exp, input int hold);
    int          lat;
    logic [31:0] held;
    logic [31:0] want;
    @(negedge clk);
    check("ready_before_issue", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1;
    x_i = x;
    y_i = y;
    op_i = op;
    ready_i = 1'b0;
    sb_q.push_back(exp);
    @(negedge clk);
    valid_i = 1'b0;
    x_i = 32'hDEAD_BEEF;
    y_i = 32'hDEAD_BEEF;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, lat_exp(y));
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_ready", {31'd0, ready_o}, 32'd0);
      check("hold_result", result_o, held);
    end
    want = sb_q.pop_front();
    check("result", result_o, want);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("post_ready", {31'd0, ready_o}, 32'd1);
    check("post_valid", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [1:0]  rop;
    rst = 1'b1;
    valid_i = 1'b0;
    x_i = 32'd0;
    y_i = 32'd0;
    op_i = 2'd0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 2'b01, 32'hFFFF_FFFF, 0);
    run_op(32'hFFFF_FFFF, 32'h10, 2'b10, 32'h0FFF_FFFF, 0);
    run_op(32'hFFFF_FFFF, 32'h10, 2'b11, 32'h0000_000F, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 0);
    run_op(32'h0000_1234, 32'd0, 2'b00, 32'hFFFF_FFFF, 0);
    run_op(32'h0000_1234, 32'd0, 2'b01, 32'h0000_1234, 0);
    run_op(32'hFFFF_FF00, 32'd0, 2'b01, 32'hFFFF_FF00, 0);
    run_op(32'd1000, 32'hFFFF_FFFD, 2'b01, 32'd1, 10);

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = (i == 0) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      rop = $urandom_range(0, 3);
      run_op(rx, ry, rop, model(rx, ry, rop), 0);
    end

    // flush in the accept cycle: nothing is taken
    @(negedge clk);
    valid_i = 1'b1;
    flush_i = 1'b1;
    x_i = 32'd50;
    y_i = 32'd5;
    op_i = 2'b00;
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_accept_ready", {31'd0, ready_o}, 32'd1);

    // flush 10 cycles into CALC
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check("calc_busy", {31'd0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check("flush_no_valid", seen, 0);
    run_op(32'd100, 32'd7, 2'b00, 32'd14, 0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    valid_i = 1'b1;
    x_i = 32'd100;
    y_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, ready_o}, 32'd1);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'hFFFF_FF9C, 32'd7, 2'b01, 32'hFFFF_FFFE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
